// File: rtl/onehot_decoder_seq_pkg.sv
// rtl/onehot_decoder_seq_pkg.sv - shared types, limits and decode helper for the registered one-hot decoder
package decoder_pkg;

   localparam int SEL_W_MIN = 1;
   localparam int SEL_W_MAX = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      STROBE = 2'd2,
      SCAN   = 2'd3
   } dec_state_t;

   // Indices at or beyond width decode to all-zero rather than an out-of-range bit.
   function automatic logic [63:0] onehot(input int unsigned idx, input int unsigned width);
      logic [63:0] r;
      r = '0;
      if (idx < width) begin
         r = 64'd1 << idx;
      end
      return r;
   endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// rtl/onehot_decoder_seq_if.sv - command and decode bundle between control logic and the decoder
interface onehot_decoder_seq_if
   import decoder_pkg::*;
#(
   parameter int SEL_W = 2
);
   localparam int OUT_W = 2 ** SEL_W;

   logic             en;
   logic             clr;
   logic             load;
   logic [SEL_W-1:0] sel;
   logic             pulse;
   logic             scan;
   logic [OUT_W-1:0] dec;
   logic             active;
   logic [SEL_W-1:0] index;

   modport master (
      output en, clr, load, sel, pulse, scan,
      input  dec, active, index
   );

   modport slave (
      input  en, clr, load, sel, pulse, scan,
      output dec, active, index
   );

endinterface

// File: rtl/onehot_decoder_seq_sel_to_onehot.sv
// rtl/onehot_decoder_seq_sel_to_onehot.sv - plain combinational SEL_W to 2**SEL_W one-hot decode
module sel_to_onehot
   import decoder_pkg::*;
#(
   parameter int SEL_W = 2,
   localparam int OUT_W = 2 ** SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_W-1:0] dec
);

   always_comb begin
      dec = OUT_W'(onehot(32'(sel), OUT_W));
   end

endmodule

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - registered one-hot decoder with hold, strobe and auto-scan modes
module onehot_decoder_seq
   import decoder_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input logic                 clk,
   input logic                 rst,
   onehot_decoder_seq_if.slave bus
);

   localparam int OUT_W = 2 ** SEL_W;

   if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX) begin : g_sel_w_range
      $error("onehot_decoder_seq: SEL_W out of legal range");
   end

   dec_state_t       state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [OUT_W-1:0] onehot_d;
   logic [OUT_W-1:0] dec_q;
   logic             active_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         dec_q    <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         dec_q    <= (state_d == IDLE) ? '0 : onehot_d;
         active_q <= (state_d != IDLE);
      end
   end

   // A disabled cycle leaves state_d/idx_d equal to the current values, so every register holds.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (!bus.en) begin
         state_d = state_q;
      end else if (bus.clr) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (bus.load) begin
         state_d = bus.pulse ? STROBE : HOLD;
         idx_d   = bus.sel;
      end else if (bus.scan) begin
         state_d = SCAN;
         idx_d   = (state_q == IDLE) ? '0 : idx_q + SEL_W'(1);
      end else begin
         case (state_q)
            STROBE, SCAN: begin
               state_d = IDLE;
               idx_d   = '0;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   sel_to_onehot #(.SEL_W(SEL_W)) u_sel_to_onehot (
      .sel (idx_d),
      .dec (onehot_d)
   );

   assign bus.dec    = dec_q;
   assign bus.active = active_q;
   assign bus.index  = idx_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - self-checking bench for onehot_decoder_seq at SEL_W 1, 2 and 4
module tb_onehot_decoder_seq;

   logic clk = 1'b0;
   bit   clk_run = 1'b1;
   logic rst;

   always #5 clk = clk_run ? ~clk : clk;

   logic       t_en, t_clr, t_load, t_pulse, t_scan;
   logic [3:0] t_sel;

   onehot_decoder_seq_if #(.SEL_W(2)) i2 ();
   onehot_decoder_seq_if #(.SEL_W(1)) i1 ();
   onehot_decoder_seq_if #(.SEL_W(4)) i4 ();

   assign i2.en = t_en;  assign i2.clr = t_clr; assign i2.load = t_load;
   assign i2.pulse = t_pulse; assign i2.scan = t_scan; assign i2.sel = t_sel[1:0];
   assign i1.en = t_en;  assign i1.clr = t_clr; assign i1.load = t_load;
   assign i1.pulse = t_pulse; assign i1.scan = t_scan; assign i1.sel = t_sel[0:0];
   assign i4.en = t_en;  assign i4.clr = t_clr; assign i4.load = t_load;
   assign i4.pulse = t_pulse; assign i4.scan = t_scan; assign i4.sel = t_sel;

   onehot_decoder_seq #(.SEL_W(2)) dut2 (.clk(clk), .rst(rst), .bus(i2));
   onehot_decoder_seq #(.SEL_W(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));
   onehot_decoder_seq #(.SEL_W(4)) dut4 (.clk(clk), .rst(rst), .bus(i4));

   int total = 0;
   int bad   = 0;

   // Reference: each decoder is "no line" (-1) or one line, plus a mode 0 none/1 hold/2 strobe/3 scan.
   int n_lines[3] = '{4, 2, 16};
   int m_line[3];
   int m_mode[3];

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m_line[k] = -1;
         m_mode[k] = 0;
      end
   endfunction

   function automatic void model_step();
      for (int k = 0; k < 3; k++) begin
         if (!t_en) continue;
         if (t_clr) begin
            m_line[k] = -1; m_mode[k] = 0;
         end else if (t_load) begin
            m_line[k] = int'(t_sel) % n_lines[k];
            m_mode[k] = t_pulse ? 2 : 1;
         end else if (t_scan) begin
            m_line[k] = (m_line[k] < 0) ? 0 : (m_line[k] + 1) % n_lines[k];
            m_mode[k] = 3;
         end else if (m_mode[k] >= 2) begin
            m_line[k] = -1; m_mode[k] = 0;
         end
      end
   endfunction

   function automatic logic [15:0] dec_of(input int k);
      case (k)
         0:       return 16'(i2.dec);
         1:       return 16'(i1.dec);
         default: return i4.dec;
      endcase
   endfunction

   function automatic int idx_of(input int k);
      case (k)
         0:       return int'(i2.index);
         1:       return int'(i1.index);
         default: return int'(i4.index);
      endcase
   endfunction

   function automatic logic act_of(input int k);
      case (k)
         0:       return i2.active;
         1:       return i1.active;
         default: return i4.active;
      endcase
   endfunction

   task automatic cyc(input logic en_, clr_, load_, input int sel_, input logic pulse_, scan_);
      t_en = en_; t_clr = clr_; t_load = load_; t_sel = 4'(sel_); t_pulse = pulse_; t_scan = scan_;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      t_en = 1'b1; t_clr = 1'b0; t_load = 1'b0; t_sel = '0; t_pulse = 1'b0; t_scan = 1'b0;
      model_reset();
      #12;
      total++;
      if (i2.dec !== 4'b0000 || i2.active !== 1'b0 || i2.index !== 2'd0) begin
         bad++; $display("FAIL reset_values got dec=%b act=%b idx=%0d want 0000/0/0", i2.dec, i2.active, i2.index);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1);
      total++;
      if (i2.dec !== 4'b0100 || i2.index !== 2'd2) begin
         bad++; $display("FAIL reset_prescan got dec=%b idx=%0d want 0100/2", i2.dec, i2.index);
      end
      clk_run = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++;
      if (i2.dec !== 4'b0000 || i2.active !== 1'b0 || i2.index !== 2'd0 || i4.dec !== 16'd0) begin
         bad++; $display("FAIL reset_async got dec=%b act=%b idx=%0d dec4=%h want 0000/0/0/0000", i2.dec, i2.active, i2.index, i4.dec);
      end
      rst = 1'b0;
      model_reset();
      #3 clk_run = 1'b1;
   endtask

   task automatic test_hold();
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 2, 0, 0);
      for (int i = 0; i <= 10; i++) begin
         total++;
         if (i2.dec !== 4'b0100 || i2.active !== 1'b1 || i2.index !== 2'd2) begin
            bad++; $display("FAIL hold cycle %0d got dec=%b act=%b idx=%0d want 0100/1/2", i, i2.dec, i2.active, i2.index);
         end
         cyc(1, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic test_pulse();
      logic [3:0] exp_b2b[3] = '{4'b0001, 4'b0010, 4'b0000};
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 3, 1, 0);
      total++;
      if (i2.dec !== 4'b1000 || i2.index !== 2'd3) begin
         bad++; $display("FAIL pulse_on got dec=%b idx=%0d want 1000/3", i2.dec, i2.index);
      end
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (i2.dec !== 4'b0000 || i2.active !== 1'b0) begin
         bad++; $display("FAIL pulse_off got dec=%b act=%b want 0000/0", i2.dec, i2.active);
      end
      for (int i = 0; i < 3; i++) begin
         if (i < 2) cyc(1, 0, 1, i, 1, 0);
         else       cyc(1, 0, 0, 0, 0, 0);
         total++;
         if (i2.dec !== exp_b2b[i]) begin
            bad++; $display("FAIL pulse_b2b step %0d got %b want %b", i, i2.dec, exp_b2b[i]);
         end
      end
   endtask

   task automatic test_scan();
      logic [3:0] want;
      cyc(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, 0, 0, 0, 1);
         want = 4'b0001 << (i % 4);
         total++;
         if (i2.dec !== want || i2.index !== 2'(i % 4)) begin
            bad++; $display("FAIL scan step %0d got dec=%b idx=%0d want %b", i, i2.dec, i2.index, want);
         end
      end
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (i2.dec !== 4'b0000 || i2.index !== 2'd0) begin
         bad++; $display("FAIL scan_exit got dec=%b idx=%0d want 0000/0", i2.dec, i2.index);
      end
   endtask

   task automatic test_priority();
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 1);
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (i2.dec !== 4'b0010) begin
         bad++; $display("FAIL load_over_scan got %b want 0010", i2.dec);
      end
      cyc(1, 0, 0, 0, 0, 1);
      total++;
      if (i2.dec !== 4'b0100) begin
         bad++; $display("FAIL scan_from_hold got %b want 0100", i2.dec);
      end
      cyc(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 1);
         total++;
         if (i2.dec !== 4'b0100 || i2.index !== 2'd2) begin
            bad++; $display("FAIL en_freeze cycle %0d got dec=%b idx=%0d want 0100/2", i, i2.dec, i2.index);
         end
      end
      cyc(1, 0, 0, 0, 0, 1);
      total++;
      if (i2.dec !== 4'b1000) begin
         bad++; $display("FAIL en_resume got %b want 1000", i2.dec);
      end
      cyc(1, 0, 1, 3, 0, 0);
      cyc(1, 1, 1, 2, 0, 0);
      total++;
      if (i2.dec !== 4'b0000 || i2.active !== 1'b0) begin
         bad++; $display("FAIL clr_over_load got dec=%b act=%b want 0000/0", i2.dec, i2.active);
      end
      cyc(1, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      total++;
      if (i2.dec !== 4'b0010) begin
         bad++; $display("FAIL strobe_frozen got %b want 0010", i2.dec);
      end
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (i2.dec !== 4'b0000) begin
         bad++; $display("FAIL strobe_resume got %b want 0000", i2.dec);
      end
   endtask

   task automatic test_parametric();
      int hits1[2];
      int hits4[16];
      hits1 = '{default: 0};
      hits4 = '{default: 0};
      cyc(1, 1, 0, 0, 0, 0);
      for (int c = 0; c < 32; c++) begin
         cyc(1, 0, 0, 0, 0, 1);
         total++;
         if ($countones(i1.dec) != 1 || i1.dec !== (2'b01 << i1.index) || i1.index !== 1'(c % 2) ||
             $countones(i4.dec) != 1 || i4.dec !== (16'd1 << i4.index) || i4.index !== 4'(c % 16)) begin
            bad++; $display("FAIL param_scan cycle %0d got dec1=%b idx1=%0d dec4=%h idx4=%0d want idx1=%0d idx4=%0d",
                            c, i1.dec, i1.index, i4.dec, i4.index, c % 2, c % 16);
         end
         for (int b = 0; b < 2; b++)  hits1[b] += int'(i1.dec[b]);
         for (int b = 0; b < 16; b++) hits4[b] += int'(i4.dec[b]);
      end
      for (int b = 0; b < 16; b++) begin
         total++;
         if (hits4[b] != 2 || (b < 2 && hits1[b] != 16)) begin
            bad++; $display("FAIL param_hits line %0d got w4=%0d w1=%0d want 2/16", b, hits4[b], (b < 2) ? hits1[b] : 16);
         end
      end
      cyc(1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [15:0] want;
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(9) != 0), ($urandom_range(19) == 0), ($urandom_range(3) == 0),
             int'($urandom_range(15)), 1'($urandom_range(1)), ($urandom_range(4) < 2));
         for (int k = 0; k < 3; k++) begin
            want = (m_line[k] < 0) ? 16'd0 : (16'd1 << m_line[k]);
            total++;
            if (dec_of(k) !== want || act_of(k) !== (m_line[k] >= 0) ||
                idx_of(k) != ((m_line[k] < 0) ? 0 : m_line[k])) begin
               bad++; $display("FAIL random cycle %0d dut %0d got dec=%h act=%b idx=%0d want dec=%h line=%0d",
                               i, k, dec_of(k), act_of(k), idx_of(k), want, m_line[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_hold();
      test_pulse();
      test_scan();
      test_priority();
      test_parametric();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
